// File: rtl/float_to_int.sv
// float_to_int: binary32 -> signed int32 (truncate toward zero), 16-bit stb/ack in and out.
// Optional build macro FLOAT_TO_INT_SATURATE_EN selects saturating special-case results.
module float_to_int #(
    parameter logic [31:0] INDEFINITE = 32'h80000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] input_a,
    input  logic        input_a_stb,
    output logic        input_a_ack,
    output logic [15:0] output_z,
    output logic        output_z_stb,
    input  logic        output_z_ack
);

    typedef enum logic [2:0] {
        GET_A,
        GET_A_LO,
        UNPACK,
        SPECIAL,
        ALIGN,
        PACK,
        PUT_Z,
        PUT_Z_LO
    } state_t;

    state_t             state_q, state_d;
    logic [31:0]        a_q, a_d;
    logic [23:0]        m_q, m_d;
    logic signed [8:0]  e_q, e_d;
    logic               s_q, s_d;
    logic [31:0]        r_q, r_d;
    logic [31:0]        z_q, z_d;
    logic               in_ack_q, in_ack_d;
    logic               out_stb_q, out_stb_d;
    logic [15:0]        out_z_q, out_z_d;

    // Raw fields of the captured float, used by the special-case checks.
    logic [7:0]         exp_f;
    logic               man_nz;
    logic [31:0]        ovf_val;
    logic [31:0]        nan_val;

    assign exp_f  = a_q[30:23];
    assign man_nz = |a_q[22:0];

`ifdef FLOAT_TO_INT_SATURATE_EN
    assign ovf_val = s_q ? 32'h80000000 : 32'h7FFFFFFF;
    assign nan_val = 32'h00000000;
`else
    assign ovf_val = INDEFINITE;
    assign nan_val = INDEFINITE;
`endif

    assign input_a_ack  = in_ack_q;
    assign output_z_stb = out_stb_q;
    assign output_z     = out_z_q;

    // Next-state, datapath and handshake decisions for the conversion sequence.
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        m_d       = m_q;
        e_d       = e_q;
        s_d       = s_q;
        r_d       = r_q;
        z_d       = z_q;
        in_ack_d  = in_ack_q;
        out_stb_d = out_stb_q;
        out_z_d   = out_z_q;

        case (state_q)
            GET_A: begin
                in_ack_d = 1'b1;
                if (in_ack_q && input_a_stb) begin
                    a_d[31:16] = input_a;
                    in_ack_d   = 1'b0;
                    state_d    = GET_A_LO;
                end
            end

            GET_A_LO: begin
                in_ack_d = 1'b1;
                if (in_ack_q && input_a_stb) begin
                    a_d[15:0] = input_a;
                    in_ack_d  = 1'b0;
                    state_d   = UNPACK;
                end
            end

            UNPACK: begin
                m_d     = {1'b1, a_q[22:0]};
                e_d     = $signed({1'b0, a_q[30:23]}) - 9'sd127;
                s_d     = a_q[31];
                state_d = SPECIAL;
            end

            SPECIAL: begin
                if (exp_f == 8'd0) begin
                    z_d     = 32'd0;
                    state_d = PUT_Z;
                end else if (e_q < 9'sd0) begin
                    z_d     = 32'd0;
                    state_d = PUT_Z;
                end else if (exp_f == 8'hFF) begin
                    z_d     = man_nz ? nan_val : ovf_val;
                    state_d = PUT_Z;
                end else if ((e_q > 9'sd31) ||
                             ((e_q == 9'sd31) && (!s_q || man_nz))) begin
                    z_d     = ovf_val;
                    state_d = PUT_Z;
                end else begin
                    r_d = {m_q, 8'd0};
                    // Already aligned when e==31; skip straight to pack.
                    state_d = (e_q == 9'sd31) ? PACK : ALIGN;
                end
            end

            ALIGN: begin
                r_d = r_q >> 1;
                e_d = e_q + 9'sd1;
                if (e_q == 9'sd30) begin
                    state_d = PACK;
                end
            end

            PACK: begin
                z_d     = s_q ? (~r_q + 32'd1) : r_q;
                state_d = PUT_Z;
            end

            PUT_Z: begin
                out_stb_d = 1'b1;
                out_z_d   = z_q[31:16];
                if (out_stb_q && output_z_ack) begin
                    out_stb_d = 1'b0;
                    state_d   = PUT_Z_LO;
                end
            end

            PUT_Z_LO: begin
                out_stb_d = 1'b1;
                out_z_d   = z_q[15:0];
                if (out_stb_q && output_z_ack) begin
                    out_stb_d = 1'b0;
                    state_d   = GET_A;
                end
            end

            default: begin
                state_d = GET_A;
            end
        endcase
    end

    // State and datapath registers; reset drops any half-moved word pair.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= GET_A;
            a_q       <= 32'd0;
            m_q       <= 24'd0;
            e_q       <= 9'sd0;
            s_q       <= 1'b0;
            r_q       <= 32'd0;
            z_q       <= 32'd0;
            in_ack_q  <= 1'b0;
            out_stb_q <= 1'b0;
            out_z_q   <= 16'd0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            m_q       <= m_d;
            e_q       <= e_d;
            s_q       <= s_d;
            r_q       <= r_d;
            z_q       <= z_d;
            in_ack_q  <= in_ack_d;
            out_stb_q <= out_stb_d;
            out_z_q   <= out_z_d;
        end
    end

endmodule
